// File: rtl/mct_if.sv
// Request/response bundle between MEM/IF requesters, the memory controller and
// the 8-bit synchronous RAM.
interface mct_if #(
   parameter int ADDR_W = 17
);
   logic              mm_mct_e;
   logic              mm_mct_wr;
   logic [31:0]       mm_mct_a;
   logic [1:0]        mm_mct_len;
   logic [31:0]       mm_mct_n_i;
   logic [31:0]       mm_mct_n_o;
   logic              mm_mct_ok;

   logic              if_mct_e;
   logic [31:0]       if_mct_a;
   logic [31:0]       if_mct_n_o;
   logic              if_mct_ok;

   logic [ADDR_W-1:0] ram_a;
   logic [7:0]        ram_dout;
   logic              ram_wr;
   logic [7:0]        ram_din;

   // slave: the controller; master: requesters plus the RAM model.
   modport slave (
      input  mm_mct_e, mm_mct_wr, mm_mct_a, mm_mct_len, mm_mct_n_i,
      input  if_mct_e, if_mct_a, ram_din,
      output mm_mct_n_o, mm_mct_ok, if_mct_n_o, if_mct_ok,
      output ram_a, ram_dout, ram_wr
   );

   modport master (
      output mm_mct_e, mm_mct_wr, mm_mct_a, mm_mct_len, mm_mct_n_i,
      output if_mct_e, if_mct_a, ram_din,
      input  mm_mct_n_o, mm_mct_ok, if_mct_n_o, if_mct_ok,
      input  ram_a, ram_dout, ram_wr
   );
endinterface

// File: rtl/mct.sv
// Memory controller: arbitrates MEM (priority) and IF requests and serializes
// 1/2/4-byte accesses onto an 8-bit synchronous RAM, little-endian.
module mct #(
   parameter int ADDR_W = 17
) (
   input  logic clk,
   input  logic rst,
   mct_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            r_state;
   logic              r_src;
   logic [ADDR_W-1:0] r_base;
   logic [2:0]        r_n;
   logic [2:0]        r_cnt;
   logic [31:0]       r_wdata;
   logic [31:0]       r_asm;
   logic [31:0]       r_mm_n_o;
   logic [31:0]       r_if_n_o;
   logic              r_mm_ok;
   logic              r_if_ok;
   logic [ADDR_W-1:0] r_ram_a;
   logic [7:0]        r_ram_dout;
   logic              r_ram_wr;

   logic [2:0]        w_cnt_inc;
   logic [2:0]        w_mm_n;
   logic [ADDR_W-1:0] w_addr_next;
   logic [7:0]        w_wbyte_next;
   logic [31:0]       w_asm_next;
   logic              w_unused;

   assign w_cnt_inc    = r_cnt + 3'd1;
   assign w_addr_next  = r_base + ADDR_W'(w_cnt_inc);
   assign w_wbyte_next = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
   assign w_mm_n       = (bus.mm_mct_len == 2'd0) ? 3'd1 :
                         (bus.mm_mct_len == 2'd1) ? 3'd2 : 3'd4;
   assign w_unused     = &{1'b0, bus.mm_mct_a[31:ADDR_W], bus.if_mct_a[31:ADDR_W]};

   // Read data arriving while r_cnt == k+1 belongs to byte lane k.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign w_asm_next[8*gi +: 8] = (r_cnt == 3'(gi + 1)) ? bus.ram_din
                                                             : r_asm[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_src      <= 1'b0;
         r_base     <= '0;
         r_n        <= 3'd0;
         r_cnt      <= 3'd0;
         r_wdata    <= 32'd0;
         r_asm      <= 32'd0;
         r_mm_n_o   <= 32'd0;
         r_if_n_o   <= 32'd0;
         r_mm_ok    <= 1'b0;
         r_if_ok    <= 1'b0;
         r_ram_a    <= '0;
         r_ram_dout <= 8'd0;
         r_ram_wr   <= 1'b0;
      end else begin
         r_mm_ok <= 1'b0;
         r_if_ok <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.mm_mct_e) begin
                  r_src      <= 1'b0;
                  r_base     <= bus.mm_mct_a[ADDR_W-1:0];
                  r_n        <= w_mm_n;
                  r_cnt      <= 3'd0;
                  r_wdata    <= bus.mm_mct_n_i;
                  r_asm      <= 32'd0;
                  r_ram_a    <= bus.mm_mct_a[ADDR_W-1:0];
                  r_ram_dout <= bus.mm_mct_n_i[7:0];
                  r_ram_wr   <= bus.mm_mct_wr;
                  r_state    <= bus.mm_mct_wr ? WR : RD;
               end else if (bus.if_mct_e) begin
                  r_src      <= 1'b1;
                  r_base     <= bus.if_mct_a[ADDR_W-1:0];
                  r_n        <= 3'd4;
                  r_cnt      <= 3'd0;
                  r_wdata    <= 32'd0;
                  r_asm      <= 32'd0;
                  r_ram_a    <= bus.if_mct_a[ADDR_W-1:0];
                  r_ram_dout <= 8'd0;
                  r_ram_wr   <= 1'b0;
                  r_state    <= RD;
               end
            end
            WR: begin
               if (r_cnt == r_n - 3'd1) begin
                  r_ram_wr <= 1'b0;
                  r_mm_ok  <= 1'b1;
                  r_state  <= DONE;
               end else begin
                  r_cnt      <= w_cnt_inc;
                  r_ram_a    <= w_addr_next;
                  r_ram_dout <= w_wbyte_next;
               end
            end
            RD: begin
               r_asm <= w_asm_next;
               r_cnt <= w_cnt_inc;
               if (r_cnt < r_n - 3'd1) begin
                  r_ram_a <= w_addr_next;
               end
               // The final byte lands one cycle after the last address.
               if (r_cnt == r_n) begin
                  if (r_src) begin
                     r_if_n_o <= w_asm_next;
                     r_if_ok  <= 1'b1;
                  end else begin
                     r_mm_n_o <= w_asm_next;
                     r_mm_ok  <= 1'b1;
                  end
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mm_mct_n_o = r_mm_n_o;
   assign bus.mm_mct_ok  = r_mm_ok;
   assign bus.if_mct_n_o = r_if_n_o;
   assign bus.if_mct_ok  = r_if_ok;
   assign bus.ram_a      = r_ram_a;
   assign bus.ram_dout   = r_ram_dout;
   assign bus.ram_wr     = r_ram_wr;
endmodule

// File: tb/tb_mct.sv
// Self-checking bench for mct: vector table, corner sequences and random
// traffic checked against a byte-array model of memory.
module tb_mct;
   localparam int AW = 17;
   localparam logic [31:0] MASK = (32'd1 << AW) - 32'd1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mct_if #(.ADDR_W(AW)) bus();

   mct #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] ram     [0:(1<<AW)-1];
   logic [7:0] ref_mem [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
      bus.ram_din <= ram[bus.ram_a];
   end

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          is_if;
      bit          wr;
      logic [31:0] a;
      logic [1:0]  len;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input bit is_if, input logic [1:0] len);
      if (is_if || len[1]) return 4;
      return (len == 2'd0) ? 1 : 2;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] r = 32'd0;
      for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[(a + 32'(k)) & MASK];
      return r;
   endfunction

   task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
      for (int k = 0; k < n; k++) ref_mem[(a + 32'(k)) & MASK] = d[8*k +: 8];
   endtask

   // Counts edges (sampled 1 time unit after each) until the chosen ok rises.
   task automatic wait_ok(input bit is_if, output int edges, output int other, output bit got);
      edges = 0; other = 0; got = 1'b0;
      while (edges < 30 && !got) begin
         @(posedge clk); #1;
         edges++;
         if (is_if ? bus.if_mct_ok : bus.mm_mct_ok) got = 1'b1;
         if (is_if ? bus.mm_mct_ok : bus.if_mct_ok) other++;
      end
   endtask

   task automatic run_req(input string name, input bit is_if, input bit wr, input logic [31:0] a,
                          input logic [1:0] len, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
      int  edges, other;
      bit  got;
      @(negedge clk);
      if (is_if) begin
         bus.if_mct_e = 1'b1; bus.if_mct_a = a;
      end else begin
         bus.mm_mct_e = 1'b1; bus.mm_mct_wr = wr; bus.mm_mct_a = a;
         bus.mm_mct_len = len; bus.mm_mct_n_i = wd;
      end
      wait_ok(is_if, edges, other, got);
      lat = edges - 1;
      rd  = is_if ? bus.if_mct_n_o : bus.mm_mct_n_o;
      bus.if_mct_e = 1'b0;
      bus.mm_mct_e = 1'b0;
      chk({name, " ok_seen"}, {31'd0, got}, 32'd1);
      chk({name, " other_ok"}, 32'(other), 32'd0);
      if (got && wr && !is_if) model_write(a, nbytes(1'b0, len), wd);
      @(posedge clk); #1;
      chk({name, " ok_width"}, {30'd0, bus.mm_mct_ok, bus.if_mct_ok}, 32'd0);
   endtask

   vec_t        tbl [11];
   logic [31:0] rd, a, lo, exp_rd, keep;
   int          lat, edges, other, n, cnt_ok;
   bit          got, is_if, wr;
   logic [1:0]  len;

   initial begin
      for (int i = 0; i < (1<<AW); i++) begin
         ram[i] = 8'h00; ref_mem[i] = 8'h00;
      end
      ram[32'h20] = 8'h5A; ref_mem[32'h20] = 8'h5A;
      bus.mm_mct_e = 0; bus.mm_mct_wr = 0; bus.mm_mct_a = 0; bus.mm_mct_len = 0;
      bus.mm_mct_n_i = 0; bus.if_mct_e = 0; bus.if_mct_a = 0; bus.ram_din = 0;

      tbl[0]  = '{0, 1, 32'h0001_FFFE, 2'd3, 32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{0, 0, 32'h0001_FFFE, 2'd3, 32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{0, 1, 32'h0000_0100, 2'd3, 32'h4433_2211, 32'h0};
      tbl[3]  = '{0, 0, 32'h0000_0103, 2'd0, 32'h0,         32'h0000_0044};
      tbl[4]  = '{0, 0, 32'h0000_0101, 2'd1, 32'h0,         32'h0000_3322};
      tbl[5]  = '{0, 1, 32'h0000_0200, 2'd1, 32'h1234_AB55, 32'h0};
      tbl[6]  = '{0, 0, 32'h0000_0200, 2'd3, 32'h0,         32'h0000_AB55};
      tbl[7]  = '{0, 1, 32'hABC3_FFFF, 2'd0, 32'h0000_0077, 32'h0};
      tbl[8]  = '{0, 0, 32'h0001_FFFE, 2'd2, 32'h0,         32'hDEAD_77EF};
      tbl[9]  = '{1, 0, 32'h0000_0100, 2'd0, 32'h0,         32'h4433_2211};
      tbl[10] = '{1, 0, 32'hFFFE_0101, 2'd0, 32'h0,         32'h0044_3322};

      // Reset state
      #1;
      chk("rst ok/wr", {29'd0, bus.mm_mct_ok, bus.if_mct_ok, bus.ram_wr}, 32'd0);
      chk("rst ram_a", 32'(bus.ram_a), 32'd0);
      chk("rst ram_dout", 32'(bus.ram_dout), 32'd0);
      chk("rst mm_n_o", bus.mm_mct_n_o, 32'd0);
      chk("rst if_n_o", bus.if_mct_n_o, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-transfer of a word write
      @(negedge clk);
      bus.mm_mct_e = 1; bus.mm_mct_wr = 1; bus.mm_mct_a = 32'h300;
      bus.mm_mct_len = 2'd3; bus.mm_mct_n_i = 32'hCAFE_F00D;
      @(posedge clk); @(posedge clk); #2;
      chk("midrst wr_before", {31'd0, bus.ram_wr}, 32'd1);
      rst_n = 1'b0; #1;
      bus.mm_mct_e = 0;
      chk("midrst ok/wr", {29'd0, bus.mm_mct_ok, bus.if_mct_ok, bus.ram_wr}, 32'd0);
      chk("midrst ram_a", 32'(bus.ram_a), 32'd0);
      chk("midrst ram_dout", 32'(bus.ram_dout), 32'd0);
      cnt_ok = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.mm_mct_ok || bus.if_mct_ok || bus.ram_wr) cnt_ok++;
      end
      chk("midrst quiet", 32'(cnt_ok), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run_req("post_rst rd", 0, 0, 32'h20, 2'd0, 32'h0, rd, lat);
      chk("post_rst data", rd, 32'h0000_005A);
      chk("post_rst lat", 32'(lat), 32'd2);

      // Vector table
      for (int i = 0; i < 11; i++) begin
         n = nbytes(tbl[i].is_if, tbl[i].len);
         run_req($sformatf("vec%0d", i), tbl[i].is_if, tbl[i].wr, tbl[i].a, tbl[i].len,
                 tbl[i].wd, rd, lat);
         chk($sformatf("vec%0d lat", i), 32'(lat), tbl[i].wr ? 32'(n) : 32'(n + 1));
         if (!tbl[i].wr) chk($sformatf("vec%0d data", i), rd, tbl[i].exp_rd);
         $display("vec%0d if=%0d wr=%0d a=%h len=%0d rd=%h lat=%0d", i, tbl[i].is_if,
                  tbl[i].wr, tbl[i].a, tbl[i].len, rd, lat);
      end
      chk("ram 1FFFE", 32'(ram[17'h1FFFE]), 32'hEF);
      chk("ram 1FFFF", 32'(ram[17'h1FFFF]), 32'h77);
      chk("ram 00000", 32'(ram[17'h00000]), 32'hAD);
      chk("ram 00001", 32'(ram[17'h00001]), 32'hDE);

      // Arbitration: MEM first, IF pending
      @(negedge clk);
      bus.mm_mct_e = 1; bus.mm_mct_wr = 0; bus.mm_mct_a = 32'h100; bus.mm_mct_len = 2'd3;
      bus.if_mct_e = 1; bus.if_mct_a = 32'h1FFFE;
      wait_ok(0, edges, other, got);
      bus.mm_mct_e = 0;
      chk("arb mm lat", 32'(edges - 1), 32'd5);
      chk("arb if_ok early", 32'(other), 32'd0);
      chk("arb mm data", bus.mm_mct_n_o, 32'h4433_2211);
      wait_ok(1, edges, other, got);
      bus.if_mct_e = 0;
      chk("arb if gap", 32'(edges), 32'd7);
      chk("arb mm_ok during if", 32'(other), 32'd0);
      chk("arb if data", bus.if_mct_n_o, 32'hDEAD_77EF);
      chk("arb mm held", bus.mm_mct_n_o, 32'h4433_2211);
      $display("arb mm=%h if=%h", bus.mm_mct_n_o, bus.if_mct_n_o);
      @(posedge clk);

      // Held request through ok: re-accepted only after DONE
      @(negedge clk);
      bus.mm_mct_e = 1; bus.mm_mct_wr = 0; bus.mm_mct_a = 32'h101; bus.mm_mct_len = 2'd1;
      wait_ok(0, edges, other, got);
      chk("held lat1", 32'(edges - 1), 32'd3);
      chk("held data1", bus.mm_mct_n_o, 32'h0000_3322);
      @(posedge clk); #1;
      chk("held ok width", {31'd0, bus.mm_mct_ok}, 32'd0);
      wait_ok(0, edges, other, got);
      bus.mm_mct_e = 0;
      chk("held gap", 32'(edges), 32'd4);
      chk("held data2", bus.mm_mct_n_o, 32'h0000_3322);
      cnt_ok = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.mm_mct_ok || bus.if_mct_ok) cnt_ok++;
      end
      chk("held no extra ok", 32'(cnt_ok), 32'd0);
      $display("held transfer gap=%0d", edges);

      // Request dropped and address changed mid-read
      @(negedge clk);
      bus.mm_mct_e = 1; bus.mm_mct_wr = 0; bus.mm_mct_a = 32'h100; bus.mm_mct_len = 2'd3;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      bus.mm_mct_e = 0; bus.mm_mct_a = 32'h200;
      wait_ok(0, edges, other, got);
      chk("drop lat", 32'(edges), 32'd4);
      chk("drop data", bus.mm_mct_n_o, 32'h4433_2211);
      cnt_ok = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.mm_mct_ok || bus.if_mct_ok) cnt_ok++;
      end
      chk("drop single ok", 32'(cnt_ok), 32'd0);
      $display("drop data=%h", bus.mm_mct_n_o);

      // Random traffic against the byte-array model
      for (int i = 0; i < 40; i++) begin
         is_if = ($urandom_range(0, 3) == 0);
         wr    = !is_if && ($urandom_range(0, 1) == 1);
         len   = 2'($urandom_range(0, 3));
         lo    = ($urandom_range(0, 1) == 1) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                             : (32'h1FFFC + 32'($urandom_range(0, 3)));
         a     = ($urandom & 32'hFFFE_0000) | lo;
         n     = nbytes(is_if, len);
         exp_rd = model_read(a, n);
         keep  = is_if ? bus.mm_mct_n_o : bus.if_mct_n_o;
         run_req($sformatf("rnd%0d", i), is_if, wr, a, len, $urandom, rd, lat);
         chk($sformatf("rnd%0d lat", i), 32'(lat), wr ? 32'(n) : 32'(n + 1));
         if (!wr) chk($sformatf("rnd%0d data", i), rd, exp_rd);
         chk($sformatf("rnd%0d other n_o", i), is_if ? bus.mm_mct_n_o : bus.if_mct_n_o, keep);
         $display("rnd%0d if=%0d wr=%0d a=%h n=%0d rd=%h lat=%0d", i, is_if, wr, a, n, rd, lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
